// File: rtl/peridot_pfc_pkg.sv
// Shared definitions for the PFC Avalon-MM bus bridge: FSM states, command
// bus layout and local IRQ register offsets.
package peridot_pfc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_WR_DONE
  } state_e;

  localparam int CMD_W       = 37;
  localparam int CMD_WR      = 36;
  localparam int CMD_ADDR_HI = 35;
  localparam int CMD_ADDR_LO = 32;
  localparam int MAX_BANK    = 4;

  localparam logic [3:0] LOC_STATUS = 4'h0;
  localparam logic [3:0] LOC_ENABLE = 4'h1;
  localparam logic [3:0] LOC_RISE   = 4'h2;
  localparam logic [3:0] LOC_FALL   = 4'h3;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/peridot_pfc_irqunit.sv
// Pin-change interrupt unit: input synchroniser, edge detection and the
// status/enable/rise/fall registers behind local addresses 0x10..0x13.
module peridot_pfc_irqunit
  import peridot_pfc_pkg::*;
#(
  parameter int PIN_NUM     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIN_NUM-1:0] din,
  input  logic               we,
  input  logic [3:0]         offset,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);

  localparam logic [31:0] PIN_MASK = (PIN_NUM >= 32) ? '1 : ((32'd1 << PIN_NUM) - 32'd1);
  localparam logic [2:0]  ARM_INIT = 3'(SYNC_STAGES + 1);

  logic [PIN_NUM-1:0] sync_q [SYNC_STAGES];
  logic [PIN_NUM-1:0] sync_d [SYNC_STAGES];
  logic [PIN_NUM-1:0] prev_q, prev_d;
  logic [2:0]         arm_q, arm_d;
  logic [31:0]        status_q, status_d;
  logic [31:0]        enable_q, enable_d;
  logic [31:0]        rise_q, rise_d;
  logic [31:0]        fall_q, fall_d;
  logic               irq_q, irq_d;

  logic [31:0] wmask, pins, prev, set;

  always_comb begin
    sync_d[0] = din;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    arm_d  = (arm_q != '0) ? arm_q - 3'd1 : arm_q;

    // The chain and previous sample start at 0 after reset, so edges are
    // ignored until both have settled to the real pin levels.
    pins = 32'(sync_q[SYNC_STAGES-1]);
    prev = 32'(prev_q);
    set  = '0;
    if (arm_q == '0) begin
      set = ((pins & ~prev & rise_q) | (~pins & prev & fall_q)) & PIN_MASK;
    end

    wmask    = be_to_mask(be) & PIN_MASK;
    status_d = status_q;
    enable_d = enable_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    if (we) begin
      unique case (offset)
        LOC_STATUS: status_d = status_q & ~(wdata & wmask);
        LOC_ENABLE: enable_d = (enable_q & ~wmask) | (wdata & wmask);
        LOC_RISE:   rise_d   = (rise_q & ~wmask) | (wdata & wmask);
        LOC_FALL:   fall_d   = (fall_q & ~wmask) | (wdata & wmask);
        default: ;
      endcase
    end
    status_d = status_d | set;
    irq_d    = |(status_q & enable_q);

    unique case (offset)
      LOC_STATUS: rdata = status_q;
      LOC_ENABLE: rdata = enable_q;
      LOC_RISE:   rdata = rise_q;
      LOC_FALL:   rdata = fall_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q   <= '0;
      arm_q    <= ARM_INIT;
      status_q <= '0;
      enable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q   <= prev_d;
      arm_q    <= arm_d;
      status_q <= status_d;
      enable_q <= enable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/peridot_pfc_busbridge.sv
// Waitrequest-based Avalon-MM bridge to the PFC command bus with configurable
// core response latency, byte-enable read-modify-write and a pin-change IRQ unit.
module peridot_pfc_busbridge
  import peridot_pfc_pkg::*;
#(
  parameter int BANK_NUM     = 4,
  parameter int RESP_LATENCY = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  input  logic [4:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [3:0]            avs_byteenable,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  avs_waitrequest,
  output logic                  coe_pfc_clk,
  output logic                  coe_pfc_reset,
  output logic [CMD_W-1:0]      coe_pfc_cmd,
  input  logic [31:0]           coe_pfc_resp,
  input  logic [BANK_NUM*8-1:0] coe_pfc_din,
  output logic                  ins_irq
);

  localparam int         PIN_NUM  = BANK_NUM * 8;
  localparam int         BANKS    = (BANK_NUM > MAX_BANK) ? MAX_BANK : BANK_NUM;
  localparam logic [2:0] BANK_LIM = 3'(BANKS);
  localparam logic [1:0] LAT_INIT = 2'(RESP_LATENCY - 1);

  state_e             state_q, state_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;

  logic        bank_ok, loc_we;
  logic [31:0] be_mask, merged, loc_rdata;

  assign bank_ok = ({1'b0, avs_address[3:2]} < BANK_LIM);
  assign loc_we  = (state_q == ST_IDLE) && avs_write && !avs_read && avs_address[4];
  assign be_mask = be_to_mask(avs_byteenable);
  assign merged  = (coe_pfc_resp & ~be_mask) | (avs_writedata & be_mask);

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    readdata_d = readdata_q;
    cmd_d      = {1'b0, cmd_q[CMD_ADDR_HI:0]};

    unique case (state_q)
      ST_IDLE: begin
        if (avs_read) begin
          if (avs_address[4]) begin
            readdata_d = loc_rdata;
            state_d    = ST_RD_DONE;
          end else if (bank_ok) begin
            cmd_d     = {1'b0, avs_address[3:0], cmd_q[31:0]};
            lat_cnt_d = LAT_INIT;
            state_d   = ST_RD_WAIT;
          end else begin
            readdata_d = '0;
            state_d    = ST_RD_DONE;
          end
        end else if (avs_write) begin
          state_d = ST_WR_DONE;
          if (!avs_address[4] && bank_ok && avs_byteenable != '0) begin
            if (avs_byteenable == '1) begin
              cmd_d = {1'b1, avs_address[3:0], avs_writedata};
            end else begin
              cmd_d     = {1'b0, avs_address[3:0], cmd_q[31:0]};
              lat_cnt_d = LAT_INIT;
              state_d   = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          readdata_d = coe_pfc_resp;
          state_d    = ST_RD_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      // Master holds writedata/byteenable while stalled, so merge straight from the bus.
      ST_RMW_RD: begin
        if (lat_cnt_q == '0) begin
          cmd_d   = {1'b1, cmd_q[CMD_ADDR_HI:CMD_ADDR_LO], merged};
          state_d = ST_RMW_WR;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      ST_RMW_WR:  state_d = ST_WR_DONE;
      ST_RD_DONE: state_d = ST_IDLE;
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      readdata_q <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      readdata_q <= readdata_d;
      cmd_q      <= cmd_d;
    end
  end

  peridot_pfc_irqunit #(
    .PIN_NUM    (PIN_NUM),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq (
    .clk   (csi_clk),
    .rst   (rsi_reset),
    .din   (coe_pfc_din),
    .we    (loc_we),
    .offset(avs_address[3:0]),
    .be    (avs_byteenable),
    .wdata (avs_writedata),
    .rdata (loc_rdata),
    .irq   (ins_irq)
  );

  assign avs_waitrequest = !(state_q == ST_RD_DONE || state_q == ST_WR_DONE);
  assign avs_readdata    = readdata_q;
  assign coe_pfc_cmd     = cmd_q;
  assign coe_pfc_clk     = csi_clk;
  assign coe_pfc_reset   = rsi_reset;

endmodule

// File: tb/tb_peridot_pfc_busbridge.sv
// Bench for peridot_pfc_busbridge (2 banks, 3-cycle core latency): directed
// vector table, randomized transactions against a reference model, IRQ/reset sequences.
module tb_peridot_pfc_busbridge;

  localparam int          BANK  = 2;
  localparam int          RL    = 3;
  localparam int          SYNC  = 2;
  localparam int          PINS  = BANK * 8;
  localparam logic [31:0] PMASK = 32'h0000FFFF;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_str;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [4:0]      avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [3:0]      avs_byteenable;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            avs_waitrequest;
  logic            coe_pfc_clk;
  logic            coe_pfc_reset;
  logic [36:0]     cmd;
  logic [31:0]     resp;
  logic [PINS-1:0] din;
  logic            ins_irq;

  peridot_pfc_busbridge #(
    .BANK_NUM    (BANK),
    .RESP_LATENCY(RL),
    .SYNC_STAGES (SYNC)
  ) dut (
    .csi_clk        (clk),
    .rsi_reset      (rst),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_byteenable (avs_byteenable),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .coe_pfc_clk    (coe_pfc_clk),
    .coe_pfc_reset  (coe_pfc_reset),
    .coe_pfc_cmd    (cmd),
    .coe_pfc_resp   (resp),
    .coe_pfc_din    (din),
    .ins_irq        (ins_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PFC core model: register file, RL-cycle read path ----------------
  logic [31:0] core_mem [16];
  logic [31:0] ref_mem  [16];
  logic [31:0] ref_loc  [4];
  logic [3:0]  ah1, ah2, raddr;
  logic        preload = 1'b1;
  int          strobe_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      2:       return 32'h12345678;
      4:       return 32'h000000A5;
      6:       return 32'hCAFE0006;
      default: return 32'h11111111 * 32'(i);
    endcase
  endfunction

  always_comb begin
    case (RL)
      1:       raddr = cmd[35:32];
      2:       raddr = ah1;
      default: raddr = ah2;
    endcase
  end
  assign resp = core_mem[raddr];

  always @(posedge clk) begin
    ah1 <= cmd[35:32];
    ah2 <= ah1;
    if (preload) begin
      for (int i = 0; i < 16; i++) core_mem[i] <= init_val(i);
    end else if (cmd[36]) begin
      core_mem[cmd[35:32]] <= cmd[31:0];
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  function automatic logic fwd_ok(input logic [4:0] a);
    return !a[4] && (int'(a[3:2]) < BANK);
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    r.exp_rd  = 32'h0;
    r.exp_str = 0;
    r.exp_lat = 1;
    if (!v.wr) begin
      if (v.addr[4]) r.exp_rd = (v.addr[3:0] < 4'd4) ? ref_loc[v.addr[1:0]] : 32'h0;
      else if (fwd_ok(v.addr)) begin
        r.exp_rd  = ref_mem[v.addr[3:0]];
        r.exp_lat = RL + 1;
      end
    end else if (fwd_ok(v.addr) && v.be != 4'h0) begin
      r.exp_str = 1;
      r.exp_lat = (v.be == 4'hF) ? 1 : RL + 2;
    end
    return r;
  endfunction

  function automatic void model_apply(input vec_t v);
    logic [31:0] m = lane_mask(v.be);
    if (!v.wr) return;
    if (fwd_ok(v.addr)) begin
      ref_mem[v.addr[3:0]] = (ref_mem[v.addr[3:0]] & ~m) | (v.data & m);
    end else if (v.addr[4] && v.addr[3:0] == 4'h0) begin
      ref_loc[0] = ref_loc[0] & ~(v.data & m & PMASK);
    end else if (v.addr[4] && v.addr[3:0] < 4'd4) begin
      ref_loc[v.addr[1:0]] = ((ref_loc[v.addr[1:0]] & ~m) | (v.data & m)) & PMASK;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic run_rec(input vec_t v, input string tag);
    int          lat;
    int          s0;
    logic        done;
    logic [31:0] rd;
    s0             = strobe_cnt;
    avs_address    = v.addr;
    avs_byteenable = v.be;
    avs_writedata  = v.data;
    avs_read       = !v.wr;
    avs_write      = v.wr;
    lat            = 0;
    done           = 1'b0;
    while (!done && lat < 20) begin
      step();
      lat++;
      if (!avs_waitrequest) done = 1'b1;
    end
    rd        = avs_readdata;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    step();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " strobes"}, 32'(strobe_cnt - s0), 32'(v.exp_str));
    if (!v.wr) chk({tag, " rdata"}, rd, v.exp_rd);
    model_apply(v);
    if (v.wr && !v.addr[4]) chk({tag, " core"}, core_mem[v.addr[3:0]], ref_mem[v.addr[3:0]]);
  endtask

  task automatic bus(input logic wr, input logic [4:0] a, input logic [3:0] be,
                     input logic [31:0] d, input string tag);
    vec_t v;
    v.wr = wr; v.addr = a; v.be = be; v.data = d;
    v = model_expect(v);
    run_rec(v, tag);
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] a, input logic [3:0] be,
                              input logic [31:0] d, input logic [31:0] rd, input int lat, input int str);
    vec_t v;
    v.wr = wr; v.addr = a; v.be = be; v.data = d;
    v.exp_rd = rd; v.exp_lat = lat; v.exp_str = str;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t tab [18];
  vec_t v;
  int   s0;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 4; i++) ref_loc[i] = 32'h0;

    tab[0]  = mk(0, 5'h04, 4'hF, 32'h0,        32'h000000A5, RL + 1, 0);
    tab[1]  = mk(1, 5'h05, 4'hF, 32'h0000FF3C, 32'h0,        1,      1);
    tab[2]  = mk(0, 5'h05, 4'hF, 32'h0,        32'h0000FF3C, RL + 1, 0);
    tab[3]  = mk(1, 5'h02, 4'h2, 32'h0000AB00, 32'h0,        RL + 2, 1);
    tab[4]  = mk(0, 5'h02, 4'hF, 32'h0,        32'h1234AB78, RL + 1, 0);
    tab[5]  = mk(1, 5'h0A, 4'hF, 32'hDEADBEEF, 32'h0,        1,      0);
    tab[6]  = mk(0, 5'h0A, 4'hF, 32'h0,        32'h00000000, 1,      0);
    tab[7]  = mk(1, 5'h06, 4'h0, 32'hFFFFFFFF, 32'h0,        1,      0);
    tab[8]  = mk(0, 5'h06, 4'hF, 32'h0,        32'hCAFE0006, RL + 1, 0);
    tab[9]  = mk(1, 5'h11, 4'hF, 32'hFFFFFF03, 32'h0,        1,      0);
    tab[10] = mk(0, 5'h11, 4'hF, 32'h0,        32'h0000FF03, 1,      0);
    tab[11] = mk(1, 5'h11, 4'h1, 32'h12345605, 32'h0,        1,      0);
    tab[12] = mk(0, 5'h11, 4'hF, 32'h0,        32'h0000FF05, 1,      0);
    tab[13] = mk(1, 5'h15, 4'hF, 32'hFFFFFFFF, 32'h0,        1,      0);
    tab[14] = mk(0, 5'h15, 4'hF, 32'h0,        32'h00000000, 1,      0);
    tab[15] = mk(1, 5'h07, 4'h9, 32'hAA0000BB, 32'h0,        RL + 2, 1);
    tab[16] = mk(0, 5'h07, 4'hF, 32'h0,        32'hAA7777BB, RL + 1, 0);
    tab[17] = mk(0, 5'h0C, 4'hF, 32'h0,        32'h00000000, 1,      0);

    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = '0; avs_writedata = '0; din = '0;
    repeat (3) step();
    chk("rst waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("rst cmd_lo", cmd[31:0], 32'h0);
    chk("rst cmd_hi", 32'(cmd[36:32]), 32'h0);
    chk("rst readdata", avs_readdata, 32'h0);
    chk("rst irq", 32'(ins_irq), 32'h0);
    chk("rst pfc_reset", 32'(coe_pfc_reset), 32'd1);
    chk("pfc_clk", 32'(coe_pfc_clk), 32'd1);
    rst = 1'b0;
    preload = 1'b0;

    for (int i = 0; i < 18; i++) run_rec(tab[i], $sformatf("tab%0d", i));

    for (int i = 0; i < 80; i++) begin
      v.wr   = 1'($urandom_range(0, 1));
      v.addr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       v.be = 4'hF;
        1:       v.be = 4'h0;
        default: v.be = 4'($urandom_range(1, 14));
      endcase
      v.data = $urandom;
      v = model_expect(v);
      run_rec(v, $sformatf("rnd%0d", i));
    end

    // Rising edge on pin 0 raises ins_irq SYNC+2 cycles after the pin changes.
    bus(1, 5'h13, 4'hF, 32'h0, "fall_en");
    bus(1, 5'h12, 4'hF, 32'h1, "rise_en");
    bus(1, 5'h11, 4'hF, 32'h1, "irq_en");
    bus(1, 5'h10, 4'hF, 32'hFFFFFFFF, "clr_all");
    din[0] = 1'b1;
    for (int k = 1; k <= SYNC + 2; k++) begin
      step();
      if (k == SYNC + 1) chk("irq early", 32'(ins_irq), 32'h0);
      if (k == SYNC + 2) chk("irq rise", 32'(ins_irq), 32'd1);
    end
    ref_loc[0] = ref_loc[0] | 32'h1;
    bus(0, 5'h10, 4'hF, 32'h0, "status_rise");

    // W1C accepted in the same cycle as a new rise: the set must win.
    din[0] = 1'b0;
    repeat (6) step();
    din[0] = 1'b1;
    repeat (SYNC) step();
    bus(1, 5'h10, 4'hF, 32'h1, "w1c_race");
    ref_loc[0] = ref_loc[0] | 32'h1;
    bus(0, 5'h10, 4'hF, 32'h0, "status_race");
    chk("irq race", 32'(ins_irq), 32'd1);
    bus(1, 5'h10, 4'hF, 32'h1, "w1c_plain");
    bus(0, 5'h10, 4'hF, 32'h0, "status_clr");
    chk("irq clr", 32'(ins_irq), 32'h0);

    // Reset while the partial write sits in RMW_RD.
    s0 = strobe_cnt;
    avs_address = 5'h03; avs_byteenable = 4'h4; avs_writedata = 32'h00990000;
    avs_write = 1'b1;
    step();
    rst = 1'b1;
    avs_write = 1'b0;
    step();
    chk("mid rst waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("mid rst cmd_lo", cmd[31:0], 32'h0);
    chk("mid rst cmd_hi", 32'(cmd[36:32]), 32'h0);
    step();
    for (int i = 0; i < 4; i++) ref_loc[i] = 32'h0;
    rst = 1'b0;
    // Pin 0 already high: the synchroniser's first rise must not latch status.
    bus(1, 5'h12, 4'hF, 32'h1, "post_rst_rise_en");
    repeat (4) step();
    chk("mid rst strobes", 32'(strobe_cnt - s0), 32'h0);
    chk("mid rst core", core_mem[3], ref_mem[3]);
    bus(0, 5'h10, 4'hF, 32'h0, "post_rst_status");
    bus(0, 5'h11, 4'hF, 32'h0, "post_rst_enable");
    chk("post rst irq", 32'(ins_irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/peridot_pfc_busbridge.md
Name: peridot_pfc_busbridge

Overview:
Parametrised successor of the PFC Avalon-MM slave interface. It is a waitrequest-based bridge with a configurable core response latency. Sub-word (byte-enable) writes are turned into read-modify-write sequences on the PFC command bus. A local pin-change interrupt unit covers up to 32 PFC pins. It sits between the Qsys interconnect and the PFC core (banks/selectors), replacing the fixed-timing bridge.

Parameters:
BANK_NUM, 4, number of 8-pin PFC banks (1..4); PIN_NUM = BANK_NUM*8
RESP_LATENCY, 1, cycles from cmd address valid to coe_pfc_resp valid (1..3)
SYNC_STAGES, 2, synchroniser depth on coe_pfc_din (2..3)

Ports:
csi_clk  in  1  single clock; all logic on rising edge
rsi_reset  in  1  synchronous, active-high reset
avs_address  in  5  [4]=0 forward to PFC reg [3:0]; [4]=1 local IRQ regs
avs_read  in  1  Avalon read
avs_write  in  1  Avalon write
avs_byteenable  in  4  byte lanes of writedata
avs_writedata  in  32  write data
avs_readdata  out  32  read data, valid when read && !waitrequest
avs_waitrequest  out  1  high except on the single completion cycle
coe_pfc_clk  out  1  = csi_clk
coe_pfc_reset  out  1  = rsi_reset
coe_pfc_cmd  out  37  [36] write strobe, [35:32] reg index, [31:0] data
coe_pfc_resp  in  32  core read data for cmd[35:32], RESP_LATENCY later
coe_pfc_din  in  PIN_NUM  raw pin levels for change detection
ins_irq  out  1  level interrupt, registered

Behaviour:
- Reset values: cmd=0, readdata=0, ins_irq=0, all IRQ regs 0, synchroniser 0, FSM=IDLE. avs_waitrequest = !(state==RD_DONE || state==WR_DONE), so it is 1 in reset and in IDLE.
- FSM states: IDLE, RD_WAIT, RD_DONE, RMW_RD, RMW_WR, WR_DONE. A down-counter lat_cnt is loaded with RESP_LATENCY-1.
- IDLE, read (read has priority if read and write are both high):
  - forwarded and bank valid: drive cmd addr, write=0; go to RD_WAIT.
  - local address: go to RD_DONE with the local value.
- RD_WAIT: hold the address; when lat_cnt==0, capture resp into readdata and go to RD_DONE. RD_DONE: complete, return to IDLE. Total read = RESP_LATENCY+2 cycles for RESP_LATENCY=1... generally accept T, completion at T+RESP_LATENCY+1.
- IDLE, write, forwarded, be==4'hF: next cycle cmd write=1 with addr and data, state WR_DONE (completion at T+1). cmd[36] is high for exactly one cycle per write.
- IDLE, write, forwarded, be partial non-zero:
  - RMW_RD: read cmd; wait RESP_LATENCY.
  - Merge: resp bytes where be=0, writedata bytes where be=1.
  - RMW_WR: one-cycle write cmd, then WR_DONE.
- be==0: no cmd issued; go to WR_DONE.
- Bank index addr[3:2] >= BANK_NUM: no cmd issued; reads return 0; writes dropped. Completes via RD_DONE/WR_DONE.
- Write-only fields (mask) return core value on RMW read-back. Software uses full-word writes for mask registers.
- cmd[35:0] holds its last value while idle.
- Local registers, byte-enable applied, bits >= PIN_NUM read 0:
  - 0x10 IRQ_STATUS (W1C)
  - 0x11 IRQ_ENABLE
  - 0x12 RISE_EN
  - 0x13 FALL_EN
  - 0x14..0x1F read 0, writes ignored.
- Edge detect on synchronised din versus its previous sample: status bit set on an enabled rise or fall.
- Simultaneous set and W1C on the same bit: set wins.
- Detection is suppressed for SYNC_STAGES+1 cycles after reset release (no spurious edges).
- ins_irq <= |(IRQ_STATUS & IRQ_ENABLE), one cycle after status/enable change.
- Reset mid-transaction: FSM to IDLE at once, no cmd write issued afterwards, pending transfer abandoned. The master is also reset.
- Master must hold address/data/be stable while waitrequest is high (Avalon rule); inputs are re-sampled only in IDLE.

Decomposition:
- Shared package peridot_pfc_pkg: FSM state encodings, local register offsets, CMD bit positions (CMD_WR=36, CMD_ADDR 35:32), MAX_BANK=4.
- One sub-module: peridot_pfc_irqunit (synchroniser, edge detect, status/enable/rise/fall regs, irq output).
- FSM and RMW merge stay in the top.

Test Plan:
- RESP_LATENCY=1: read addr 0x04, core resp=0x000000A5 → waitrequest low at T+2, readdata=0xA5, cmd[36] never high.
- Full write addr 0x05, data 0x0000FF3C, be=F → cmd=1_0101_0000FF3C for exactly one cycle at T+1, waitrequest low at T+1.
- RESP_LATENCY=3: write addr 0x02, be=4'b0010, data 0x0000AB00, resp 0x12345678 → read cmd, then write cmd data 0x1234AB78, completion at T+5.
- BANK_NUM=2: write addr 0x0A → no cmd[36] pulse. Read addr 0x0A → 0x00000000 after 2 cycles.
- RISE_EN=0x1, IRQ_ENABLE=0x1, din[0] 0→1 → ins_irq high SYNC_STAGES+2 cycles later. W1C 0x10=0x1 in the same cycle as a new rise → status stays 1.
- Assert rsi_reset during RMW_RD → next cycle waitrequest=1, cmd=0, no write strobe. Pulse din in the first 2 cycles after reset → IRQ_STATUS stays 0.
